// File: rtl/envelope_pkg.sv
// rtl/envelope_pkg.sv - shared sample width, type and limits for the envelope follower
package envelope_pkg;

    localparam int SAMPLE_WIDTH = 12;

    typedef logic [SAMPLE_WIDTH-1:0] Sample;

    localparam Sample MAX_SAMPLE = {SAMPLE_WIDTH{1'b1}};

endpackage

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational AddOperation/SubtractOperation: wrapped results plus carry/borrow
module addsub_core
    import envelope_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic [WIDTH-1:0] sum,
    output logic             sumOverflow,
    output logic [WIDTH-1:0] diff,
    output logic             diffOverflow
);

    // Widening by one bit turns the top result bit into carry (add) or borrow (subtract).
    assign {sumOverflow, sum}   = {1'b0, lhs} + {1'b0, rhs};
    assign {diffOverflow, diff} = {1'b0, lhs} - {1'b0, rhs};

endmodule

// File: rtl/envelope_addsub_unit.sv
// rtl/envelope_addsub_unit.sv - registered attack/release step unit with saturation and zero flag
module envelope_addsub_unit
    import envelope_pkg::*;
#(
    parameter int WIDTH = SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             outValid,
    output logic [WIDTH-1:0] sum,
    output logic             sumOverflow,
    output logic [WIDTH-1:0] sumSat,
    output logic [WIDTH-1:0] diff,
    output logic             diffOverflow,
    output logic [WIDTH-1:0] diffSat,
    output logic             diffZero
);

    logic [WIDTH-1:0] coreSum;
    logic [WIDTH-1:0] coreDiff;
    logic             coreSumOverflow;
    logic             coreDiffOverflow;
    logic [WIDTH-1:0] nextSumSat;
    logic [WIDTH-1:0] nextDiffSat;

    addsub_core #(
        .WIDTH(WIDTH)
    ) core (
        .lhs         (lhs),
        .rhs         (rhs),
        .sum         (coreSum),
        .sumOverflow (coreSumOverflow),
        .diff        (coreDiff),
        .diffOverflow(coreDiffOverflow)
    );

    assign nextSumSat  = coreSumOverflow  ? {WIDTH{1'b1}} : coreSum;
    assign nextDiffSat = coreDiffOverflow ? '0            : coreDiff;

    // Results only load on valid operands so they hold while idle; all fields share one enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid     <= 1'b0;
            sum          <= '0;
            sumOverflow  <= 1'b0;
            sumSat       <= '0;
            diff         <= '0;
            diffOverflow <= 1'b0;
            diffSat      <= '0;
            diffZero     <= 1'b0;
        end else begin
            outValid <= inValid;
            if (inValid) begin
                sum          <= coreSum;
                sumOverflow  <= coreSumOverflow;
                sumSat       <= nextSumSat;
                diff         <= coreDiff;
                diffOverflow <= coreDiffOverflow;
                diffSat      <= nextDiffSat;
                diffZero     <= (nextDiffSat == '0);
            end
        end
    end

endmodule

// File: tb/tb_envelope_addsub_unit.sv
// tb/tb_envelope_addsub_unit.sv - scoreboard bench for envelope_addsub_unit
module tb_envelope_addsub_unit;
    import envelope_pkg::*;

    typedef struct packed {
        logic        outValid;
        logic [11:0] sum;
        logic        sumOverflow;
        logic [11:0] sumSat;
        logic [11:0] diff;
        logic        diffOverflow;
        logic [11:0] diffSat;
        logic        diffZero;
    } Result;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic [11:0] lhs = '0;
    logic [11:0] rhs = '0;
    logic        outValid;
    logic [11:0] sum;
    logic        sumOverflow;
    logic [11:0] sumSat;
    logic [11:0] diff;
    logic        diffOverflow;
    logic [11:0] diffSat;
    logic        diffZero;

    int    asserts = 0;
    int    failures = 0;
    Result expQueue[$];
    Result held = '0;

    envelope_addsub_unit #(.WIDTH(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .inValid     (inValid),
        .lhs         (lhs),
        .rhs         (rhs),
        .outValid    (outValid),
        .sum         (sum),
        .sumOverflow (sumOverflow),
        .sumSat      (sumSat),
        .diff        (diff),
        .diffOverflow(diffOverflow),
        .diffSat     (diffSat),
        .diffZero    (diffZero)
    );

    always #5 clk = ~clk;

    // Reference in plain integer arithmetic rather than bit-slicing.
    function automatic Result model(input int l, input int r);
        Result e;
        int s;
        int d;
        s = l + r;
        d = l - r;
        e.outValid     = 1'b1;
        e.sumOverflow  = (s > 4095);
        e.sum          = 12'(s % 4096);
        e.sumSat       = (s > 4095) ? MAX_SAMPLE : 12'(s);
        e.diffOverflow = (d < 0);
        e.diff         = 12'((d + 4096) % 4096);
        e.diffSat      = (d < 0) ? 12'd0 : 12'(d);
        e.diffZero     = (d <= 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input Result e);
        check({tag, ".outValid"}, 16'(outValid), 16'(e.outValid));
        check({tag, ".sum"}, 16'(sum), 16'(e.sum));
        check({tag, ".sumOverflow"}, 16'(sumOverflow), 16'(e.sumOverflow));
        check({tag, ".sumSat"}, 16'(sumSat), 16'(e.sumSat));
        check({tag, ".diff"}, 16'(diff), 16'(e.diff));
        check({tag, ".diffOverflow"}, 16'(diffOverflow), 16'(e.diffOverflow));
        check({tag, ".diffSat"}, 16'(diffSat), 16'(e.diffSat));
        check({tag, ".diffZero"}, 16'(diffZero), 16'(e.diffZero));
    endtask

    // Drive one cycle of stimulus, then compare the registered outputs against the scoreboard.
    task automatic step(input string tag, input logic v, input int l, input int r);
        Result e;
        @(negedge clk);
        inValid = v;
        lhs = 12'(l);
        rhs = 12'(r);
        if (v && !rst) expQueue.push_back(model(l, r));
        @(posedge clk);
        #1;
        if (rst) begin
            held = '0;
            checkAll(tag, held);
        end else if (v) begin
            check({tag, ".queue"}, 16'(expQueue.size() > 0), 16'd1);
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                held = e;
                checkAll(tag, e);
            end
        end else begin
            e = held;
            e.outValid = 1'b0;
            checkAll(tag, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        step("reset0", 1'b1, 100, 50);
        step("reset1", 1'b1, 100, 50);
        rst = 1'b0;
        step("afterReset", 1'b1, 100, 50);
        check("afterReset.sumLit", 16'(sum), 16'd150);
        check("afterReset.diffLit", 16'(diff), 16'd50);

        step("nominal", 1'b1, 1000, 200);
        check("nominal.sumLit", 16'(sum), 16'd1200);
        check("nominal.diffLit", 16'(diff), 16'd800);

        step("addOvf", 1'b1, 4000, 200);
        check("addOvf.sumLit", 16'(sum), 16'd104);
        check("addOvf.satLit", 16'(sumSat), 16'd4095);
        check("addOvf.flagLit", 16'(sumOverflow), 16'd1);

        step("addExact", 1'b1, 4095, 1);
        check("addExact.sumLit", 16'(sum), 16'd0);
        check("addExact.flagLit", 16'(sumOverflow), 16'd1);

        step("borrow", 1'b1, 100, 300);
        check("borrow.diffLit", 16'(diff), 16'd3896);
        check("borrow.satLit", 16'(diffSat), 16'd0);
        check("borrow.zeroLit", 16'(diffZero), 16'd1);

        step("equal", 1'b1, 300, 300);
        check("equal.zeroLit", 16'(diffZero), 16'd1);
        check("equal.flagLit", 16'(diffOverflow), 16'd0);

        step("rhsZero", 1'b1, 777, 0);
        step("lhsZero", 1'b1, 0, 9);

        step("b2b0", 1'b1, 10, 5);
        check("b2b0.sumLit", 16'(sum), 16'd15);
        step("b2b1", 1'b1, 20, 5);
        check("b2b1.sumLit", 16'(sum), 16'd25);
        step("b2b2", 1'b1, 30, 5);
        check("b2b2.sumLit", 16'(sum), 16'd35);
        step("idle0", 1'b0, 1, 2);
        check("idle0.sumLit", 16'(sum), 16'd35);
        step("idle1", 1'b0, 3, 4);

        for (int i = 0; i < 1000; i++) begin
            step("sweep", ($urandom_range(0, 9) != 0), int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 4095)));
        end

        rst = 1'b1;
        step("lateReset", 1'b1, 4095, 4095);
        rst = 1'b0;
        check("queueEmpty", 16'(expQueue.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
